// File: rtl/dense_argmax.sv
// Argmax over the dense layer output buffer: scans CLASS_COUNT signed scores and
// presents the winning index on a valid/ready handshake. Define DENSE_ARGMAX_SCORE_OUT_EN to expose classScore.
module dense_argmax #(
  parameter int CLASS_COUNT = 10,
  parameter int DATA_SIZE   = 16,
  localparam int ADR_W      = $clog2(CLASS_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic [ADR_W-1:0]     bufferAdr,
  input  logic [DATA_SIZE-1:0] bufferData,
  // classValid/classReady: a result transfers on any rising edge where both are high;
  // classValid holds with classIdx stable until that edge and never drops early.
  output logic                 classValid,
  input  logic                 classReady,
  output logic [ADR_W-1:0]     classIdx,
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
  output logic [DATA_SIZE-1:0] classScore,
`endif
  output logic [1:0]           dbgState
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]                  state;
  logic [ADR_W-1:0]            cnt;
  logic signed [DATA_SIZE-1:0] bestScore;
  logic [ADR_W-1:0]            bestIdx;
  logic signed [DATA_SIZE-1:0] dataS;
  logic                        takeNew;
  logic                        lastAdr;
  logic signed [DATA_SIZE-1:0] nextBest;
  logic [ADR_W-1:0]            nextIdx;

  assign dataS      = bufferData;
  assign bufferAdr  = cnt;
  assign busy       = (state != IDLE);
  assign classValid = (state == HOLD);
  assign dbgState   = state;
  assign lastAdr    = (cnt == ADR_W'(CLASS_COUNT - 1));

  // Slot 0 seeds the running best; later slots win only on a strictly larger score,
  // so ties keep the lowest index.
  always_comb begin
    takeNew  = (cnt == '0) || (dataS > bestScore);
    nextBest = takeNew ? dataS : bestScore;
    nextIdx  = takeNew ? cnt : bestIdx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bestScore  <= '0;
      bestIdx    <= '0;
      classIdx   <= '0;
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
      classScore <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            cnt   <= '0;
          end
        end
        SCAN: begin
          bestScore <= nextBest;
          bestIdx   <= nextIdx;
          if (lastAdr) begin
            // Result registers update only here, so they stay stable through HOLD and IDLE.
            cnt        <= '0;
            state      <= HOLD;
            classIdx   <= nextIdx;
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
            classScore <= nextBest;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (classReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_argmax.sv
// Directed self-checking bench for dense_argmax: reset, scans, signed ties,
// backpressure, ignored start and mid-scan reset.
module tb_dense_argmax;
  localparam int CC = 10;
  localparam int DW = 16;
  localparam int AW = $clog2(CC);
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic [AW-1:0] bufferAdr;
  logic [DW-1:0] bufferData;
  logic          classValid;
  logic          classReady = 1'b0;
  logic [AW-1:0] classIdx;
  logic [1:0]    dbgState;
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
  logic [DW-1:0] classScore;
`endif

  logic [DW-1:0] mem [CC];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign bufferData = (int'(bufferAdr) < CC) ? mem[bufferAdr] : '0;

  dense_argmax #(.CLASS_COUNT(CC), .DATA_SIZE(DW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .bufferAdr(bufferAdr),
    .bufferData(bufferData),
    .classValid(classValid),
    .classReady(classReady),
    .classIdx(classIdx),
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
    .classScore(classScore),
`endif
    .dbgState(dbgState)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(classValid), 32'd0);
    check({tag, "_adr"}, 32'(bufferAdr), 32'd0);
  endtask

  task automatic checkScore(input logic [DW-1:0] expScore);
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
    check("classScore", 32'(classScore), 32'(expScore));
`else
    if (expScore === 'x) $display("[TB] unused score");
`endif
  endtask

  task automatic loadMem(input logic [DW-1:0] v [CC]);
    for (int i = 0; i < CC; i++) mem[i] = v[i];
  endtask

  // Full scan with classReady already high: checks address per cycle, valid latency and result.
  task automatic runScan(input int expIdx, input logic [DW-1:0] expScore);
    @(posedge clk); #1 start = 1'b1; classReady = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < CC; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      check("scanAdr", 32'(bufferAdr), 32'(k));
      check("scanBusy", 32'(busy), 32'd1);
      check("scanValid", 32'(classValid), 32'd0);
    end
    @(posedge clk); @(negedge clk);
    check("holdValid", 32'(classValid), 32'd1);
    check("holdIdx", 32'(classIdx), 32'(expIdx));
    checkScore(expScore);
    @(posedge clk); @(negedge clk);
    checkIdle("afterXfer");
    check("afterXferState", 32'(dbgState), 32'(ST_IDLE));
    check("afterXferIdx", 32'(classIdx), 32'(expIdx));
  endtask

  initial begin
    logic [DW-1:0] v [CC];
    int validCount;

    // Reset and idle behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle("inReset");
    check("inResetIdx", 32'(classIdx), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    checkIdle("postReset");
    check("postResetIdx", 32'(classIdx), 32'd0);
    check("postResetState", 32'(dbgState), 32'(ST_IDLE));
    checkScore(16'd0);
    @(posedge clk); #1 classReady = 1'b1;
    @(posedge clk); #1 classReady = 1'b0;
    @(negedge clk);
    checkIdle("readyInIdle");

    // Basic scan
    v = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd11};
    loadMem(v);
    runScan(2, 16'd12);

    // All negative with a tie at the maximum
    v = '{-16'sd9, -16'sd2, -16'sd2, -16'sd8, -16'sd10, -16'sd11, -16'sd12, -16'sd13, -16'sd14, -16'sd20};
    loadMem(v);
    runScan(1, 16'hFFFE);

    // Max in the last slot, most negative value in slot 0
    v = '{16'h8000, 16'sd100, -16'sd1, 16'sd200, 16'sd0, 16'sd3, 16'h7FFE, 16'sd5, 16'sd6, 16'h7FFF};
    loadMem(v);
    runScan(9, 16'h7FFF);

    // Backpressure: result must hold while start and buffer data wiggle
    v = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd11};
    loadMem(v);
    @(posedge clk); #1 start = 1'b1; classReady = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (CC) @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bpValid", 32'(classValid), 32'd1);
      check("bpIdx", 32'(classIdx), 32'd2);
      check("bpBusy", 32'(busy), 32'd1);
      start = (c % 2 == 0);
      mem[c % CC] = 16'h7000;
      @(posedge clk);
    end
    #1 start = 1'b0; classReady = 1'b1;
    @(negedge clk);
    check("bpFinalValid", 32'(classValid), 32'd1);
    checkScore(16'd12);
    @(posedge clk); @(negedge clk);
    checkIdle("bpAfterXfer");
    @(posedge clk); @(negedge clk);
    checkIdle("bpNoRestart");

    // Second start during SCAN is ignored
    loadMem(v);
    v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd50, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
    loadMem(v);
    validCount = 0;
    @(posedge clk); #1 start = 1'b1; classReady = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (classValid) begin
        validCount++;
        check("dupIdx", 32'(classIdx), 32'd4);
      end
      @(posedge clk);
    end
    check("dupValidCount", 32'(validCount), 32'd1);

    // Mid-scan asynchronous reset, then a clean scan
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkIdle("midReset");
    check("midResetIdx", 32'(classIdx), 32'd0);
    checkScore(16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkIdle("afterMidReset");
    v = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd0};
    loadMem(v);
    runScan(6, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
